// File: rtl/pc_predictor.sv
// rtl/pc_predictor.sv - fetch PC owner with 2-bit-counter branch prediction
module pc_predictor #(
  parameter int          BHT_INDEX_BITS = 8,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic        in_fetch_ena,
  input  logic [31:0] in_inst,
  input  logic        in_rollback,
  input  logic [31:0] in_rollback_pc,
  input  logic        in_commit_branch,
  input  logic [31:0] in_commit_pc,
  input  logic        in_commit_taken,
  output logic [31:0] out_pc,
  output logic        out_predict_taken
);

  localparam int ENTRIES = 1 << BHT_INDEX_BITS;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [ENTRIES-1:0][1:0]   bht;
  logic [BHT_INDEX_BITS-1:0] fetch_idx;
  logic [BHT_INDEX_BITS-1:0] commit_idx;
  logic [1:0]                commit_ctr;
  logic                      is_branch;
  logic                      is_jal;
  logic [31:0]               imm_b;
  logic [31:0]               imm_j;
  logic [31:0]               next_pc;
  logic                      unused_commit_bits;

  assign fetch_idx  = out_pc[BHT_INDEX_BITS+1:2];
  assign commit_idx = in_commit_pc[BHT_INDEX_BITS+1:2];
  assign commit_ctr = bht[commit_idx];

  // The counter has no tag, so only the index bits of the commit PC matter.
  assign unused_commit_bits = ^{in_commit_pc[31:BHT_INDEX_BITS+2], in_commit_pc[1:0]};

  assign is_branch = (in_inst[6:0] == OP_BRANCH);
  assign is_jal    = (in_inst[6:0] == OP_JAL);

  assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  always_comb begin
    out_predict_taken = 1'b0;
    if (is_branch) begin
      out_predict_taken = bht[fetch_idx][1];
    end else if (is_jal) begin
      out_predict_taken = 1'b1;
    end
  end

  // JALR is deliberately not predicted; the ROB redirects it through rollback.
  always_comb begin
    next_pc = out_pc + 32'd4;
    if (is_branch && bht[fetch_idx][1]) begin
      next_pc = out_pc + imm_b;
    end else if (is_jal) begin
      next_pc = out_pc + imm_j;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pc <= RESET_PC;
    end else if (in_rollback) begin
      out_pc <= in_rollback_pc;
    end else if (ena && in_fetch_ena) begin
      out_pc <= next_pc;
    end
  end

  // Training never stalls: commits are applied whatever the fetch side is doing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bht <= {ENTRIES{2'b01}};
    end else if (in_commit_branch) begin
      if (in_commit_taken) begin
        if (commit_ctr != 2'b11) begin
          bht[commit_idx] <= commit_ctr + 2'b01;
        end
      end else begin
        if (commit_ctr != 2'b00) begin
          bht[commit_idx] <= commit_ctr - 2'b01;
        end
      end
    end
  end

endmodule
